// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared state encoding and memory constants for the MIPS memory responder.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
  localparam int RAM_DEPTH = 256;
  localparam logic [7:0] IO_ADDR_DEFAULT = 8'hFF;
endpackage

// File: rtl/mem_array_256x8.sv
// mem_array_256x8: unreset RAM with one clocked write port and one combinational read port.
module mem_array_256x8 #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  assign rd = mem[ra];
endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: boot-loaded unified RAM for the multicycle MIPS core, with an IO output register.
import mips_mem_pkg::*;

module mips_mem_responder #(
  parameter int                ADDR_W         = 8,
  parameter int                DATA_W         = 8,
  parameter logic [ADDR_W-1:0] IO_ADDR        = IO_ADDR_DEFAULT,
  parameter int                RELEASE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  output logic              cpu_reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe
);
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [3:0]        rel_cnt;
  logic              load_acc, cpu_we, we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd, rd;

  // load_ready is high exactly while in LOAD, so it doubles as the loader's write enable gate
  assign load_acc = load_valid && load_ready;
  assign cpu_we   = (state == RUN) && memwrite;
  assign we       = load_acc || cpu_we;
  assign wa       = load_acc ? ptr : adr;
  assign wd       = load_acc ? load_data : writedata;
  assign memdata  = (state == RUN && memread) ? rd : '0;

  mem_array_256x8 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk),
    .we (we),
    .wa (wa),
    .wd (wd),
    .ra (adr),
    .rd (rd)
  );

  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      remaining  <= '0;
      rel_cnt    <= '0;
      cpu_reset  <= 1'b1;
      load_ready <= 1'b0;
      load_done  <= 1'b0;
      io_out     <= '0;
      io_strobe  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      io_strobe <= cpu_we && adr == IO_ADDR;
      if (cpu_we && adr == IO_ADDR) io_out <= writedata;
      case (state)
        IDLE, RUN:
          if (load_start) begin
            state      <= LOAD;
            ptr        <= '0;
            remaining  <= {~|load_len, load_len};
            cpu_reset  <= 1'b1;
            load_ready <= 1'b1;
          end
        LOAD:
          if (load_acc) begin
            ptr       <= ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              state      <= RELEASE;
              rel_cnt    <= 4'(RELEASE_CYCLES);
              load_ready <= 1'b0;
            end
          end
        RELEASE:
          if (rel_cnt == 4'd1) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
          end else rel_cnt <= rel_cnt - 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: directed self-checking bench for the MIPS memory responder.
module tb_mips_mem_responder;
  logic       clk = 0, reset = 1;
  logic       memread = 0, memwrite = 0;
  logic [7:0] adr = 0, writedata = 0, memdata;
  logic       cpu_reset;
  logic       load_start = 0, load_valid = 0;
  logic [7:0] load_len = 0, load_data = 0;
  logic       load_ready, load_done, io_strobe;
  logic [7:0] io_out;
  int checks = 0, errors = 0;

  mips_mem_responder dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .adr(adr),
    .writedata(writedata), .memdata(memdata), .cpu_reset(cpu_reset),
    .load_start(load_start), .load_len(load_len), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .io_out(io_out), .io_strobe(io_strobe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [7:0] len);
    load_len = len;
    load_start = 1;
    tick();
    load_start = 0;
  endtask

  task automatic feed(input logic [7:0] d);
    load_valid = 1;
    load_data = d;
    tick();
    load_valid = 0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    memwrite = 1;
    adr = a;
    writedata = d;
    tick();
    memwrite = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    reset = 0;
    memread = 1;
    #1;
    checks += 6;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b expected 1", cpu_reset); end
    if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready: got %b expected 0", load_ready); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b expected 0", load_done); end
    if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out: got %h expected 00", io_out); end
    if (io_strobe !== 1'b0) begin errors++; $display("FAIL reset_io_strobe: got %b expected 0", io_strobe); end
    if (memdata !== 8'h00) begin errors++; $display("FAIL reset_memdata: got %h expected 00", memdata); end
    memread = 0;
  endtask

  task automatic test_basic_load();
    logic [7:0] b [4] = '{8'h80, 8'h01, 8'h00, 8'h80};
    start_load(8'd4);
    checks += 2;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_on: got %b expected 1", load_ready); end
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_cpu_reset_load: got %b expected 1", cpu_reset); end
    for (int i = 0; i < 4; i++) feed(b[i]);
    checks += 2;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_off: got %b expected 0", load_ready); end
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_release1: got %b expected 1", cpu_reset); end
    tick();
    checks += 2;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL basic_release2: got %b expected 1", cpu_reset); end
    if (load_done !== 1'b0) begin errors++; $display("FAIL basic_done_early: got %b expected 0", load_done); end
    tick();
    checks += 2;
    if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_run: got %b expected 0", cpu_reset); end
    if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse: got %b expected 1", load_done); end
    tick();
    checks++;
    if (load_done !== 1'b0) begin errors++; $display("FAIL basic_done_once: got %b expected 0", load_done); end
    memread = 1;
    for (int i = 0; i < 4; i++) begin
      adr = 8'(i);
      #1;
      checks++;
      if (memdata !== b[i]) begin errors++; $display("FAIL basic_ram[%0d]: got %h expected %h", i, memdata, b[i]); end
    end
    memread = 0;
  endtask

  task automatic test_back_pressure();
    logic [7:0] b [4] = '{8'h80, 8'h01, 8'h00, 8'h80};
    logic [6:0] pat = 7'b1011001;
    int k = 0;
    for (int i = 0; i < 4; i++) cpu_write(8'(i), 8'hEE);
    start_load(8'd4);
    for (int i = 0; i < 7; i++) begin
      load_valid = pat[i];
      load_data = pat[i] ? b[k] : 8'hFF;
      load_start = (i == 1);
      load_len = 8'd1;
      if (pat[i]) k++;
      tick();
      load_valid = 0;
      load_start = 0;
      checks++;
      if (load_ready !== (i < 6)) begin errors++; $display("FAIL bp_ready_%0d: got %b expected %b", i, load_ready, i < 6); end
    end
    tick();
    tick();
    checks += 2;
    if (cpu_reset !== 1'b0) begin errors++; $display("FAIL bp_run: got %b expected 0", cpu_reset); end
    if (load_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", load_done); end
    memread = 1;
    for (int i = 0; i < 4; i++) begin
      adr = 8'(i);
      #1;
      checks++;
      if (memdata !== b[i]) begin errors++; $display("FAIL bp_ram[%0d]: got %h expected %h", i, memdata, b[i]); end
    end
    memread = 0;
  endtask

  task automatic test_cpu_io();
    memwrite = 1;
    adr = 8'h10;
    writedata = 8'h5A;
    #1;
    checks++;
    if (memdata !== 8'h00) begin errors++; $display("FAIL io_noread_gate: got %h expected 00", memdata); end
    tick();
    memwrite = 0;
    memread = 1;
    #1;
    checks++;
    if (memdata !== 8'h5A) begin errors++; $display("FAIL io_store_load: got %h expected 5a", memdata); end
    memread = 0;
    checks++;
    if (io_strobe !== 1'b0) begin errors++; $display("FAIL io_no_strobe: got %b expected 0", io_strobe); end
    cpu_write(8'hFF, 8'h2C);
    checks += 2;
    if (io_out !== 8'h2C) begin errors++; $display("FAIL io_out: got %h expected 2c", io_out); end
    if (io_strobe !== 1'b1) begin errors++; $display("FAIL io_strobe_on: got %b expected 1", io_strobe); end
    tick();
    checks += 2;
    if (io_strobe !== 1'b0) begin errors++; $display("FAIL io_strobe_off: got %b expected 0", io_strobe); end
    if (io_out !== 8'h2C) begin errors++; $display("FAIL io_out_hold: got %h expected 2c", io_out); end
    memread = 1;
    adr = 8'hFF;
    #1;
    checks++;
    if (memdata !== 8'h2C) begin errors++; $display("FAIL io_ram_ff: got %h expected 2c", memdata); end
    memread = 0;
  endtask

  task automatic test_rw_gating();
    cpu_write(8'h20, 8'h11);
    memread = 1;
    memwrite = 1;
    adr = 8'h20;
    writedata = 8'h22;
    #1;
    checks++;
    if (memdata !== 8'h11) begin errors++; $display("FAIL rw_prewrite: got %h expected 11", memdata); end
    tick();
    memwrite = 0;
    #1;
    checks++;
    if (memdata !== 8'h22) begin errors++; $display("FAIL rw_postwrite: got %h expected 22", memdata); end
    memread = 0;
    start_load(8'd1);
    memwrite = 1;
    memread = 1;
    adr = 8'h20;
    writedata = 8'h99;
    #1;
    checks++;
    if (memdata !== 8'h00) begin errors++; $display("FAIL gate_load_read: got %h expected 00", memdata); end
    tick();
    memwrite = 0;
    memread = 0;
    feed(8'h80);
    tick();
    tick();
    memread = 1;
    adr = 8'h20;
    #1;
    checks++;
    if (memdata !== 8'h22) begin errors++; $display("FAIL gate_load_write: got %h expected 22", memdata); end
    adr = 8'h00;
    #1;
    checks++;
    if (memdata !== 8'h80) begin errors++; $display("FAIL gate_loaded0: got %h expected 80", memdata); end
    memread = 0;
  endtask

  task automatic test_full_depth();
    start_load(8'd0);
    for (int i = 0; i < 255; i++) feed(8'(i));
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL full_ready_255: got %b expected 1", load_ready); end
    feed(8'hFF);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready_256: got %b expected 0", load_ready); end
    tick();
    tick();
    checks++;
    if (load_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", load_done); end
    memread = 1;
    for (int i = 0; i < 256; i++) begin
      adr = 8'(i);
      #1;
      checks++;
      if (memdata !== 8'(i)) begin errors++; $display("FAIL full_ram[%0d]: got %h expected %h", i, memdata, 8'(i)); end
    end
    memread = 0;
  endtask

  task automatic test_reset_reload();
    start_load(8'd4);
    checks++;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reload_cpu_reset: got %b expected 1", cpu_reset); end
    feed(8'hA1);
    feed(8'hA2);
    reset = 1;
    tick();
    reset = 0;
    tick();
    checks += 3;
    if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_mid_cpu_reset: got %b expected 1", cpu_reset); end
    if (load_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", load_ready); end
    if (io_out !== 8'h00) begin errors++; $display("FAIL rst_mid_io_out: got %h expected 00", io_out); end
    start_load(8'd1);
    feed(8'h5B);
    tick();
    tick();
    checks++;
    if (cpu_reset !== 1'b0) begin errors++; $display("FAIL rst_run: got %b expected 0", cpu_reset); end
    memread = 1;
    adr = 8'h00;
    #1;
    checks++;
    if (memdata !== 8'h5B) begin errors++; $display("FAIL rst_ram0: got %h expected 5b", memdata); end
    adr = 8'h01;
    #1;
    checks++;
    if (memdata !== 8'hA2) begin errors++; $display("FAIL rst_ram1_kept: got %h expected a2", memdata); end
    adr = 8'h02;
    #1;
    checks++;
    if (memdata !== 8'h02) begin errors++; $display("FAIL rst_ram2_kept: got %h expected 02", memdata); end
    memread = 0;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_back_pressure();
    test_cpu_io();
    test_rw_gating();
    test_full_depth();
    test_reset_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the 8-bit multicycle MIPS core.
- Provides a 256x8 unified instruction/data RAM with combinational read and a clocked write, matching the core's memread/memwrite/adr/writedata/memdata interface.
- Contains a boot-loader FSM that fills the RAM from a valid/ready byte stream while holding the core in reset, then releases it.
- Provides one memory-mapped output register for observing program results.

Parameters:
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W.
- DATA_W, 8, data width.
- IO_ADDR, 8'hFF, address whose CPU writes also update io_out.
- RELEASE_CYCLES, 2, cycles cpu_reset stays high after the last loaded byte (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- memread  in  1  CPU read strobe.
- memwrite  in  1  CPU write strobe.
- adr  in  ADDR_W  CPU byte address.
- writedata  in  DATA_W  CPU store data.
- memdata  out  DATA_W  read data to CPU.
- cpu_reset  out  1  synchronous reset driven to the core.
- load_start  in  1  one-cycle request to (re)load the program.
- load_len  in  ADDR_W  byte count, sampled with load_start; 0 means 256.
- load_valid  in  1  load byte valid.
- load_data  in  DATA_W  load byte.
- load_ready  out  1  loader accepts a byte.
- load_done  out  1  one-cycle pulse on entry to RUN.
- io_out  out  DATA_W  last value the CPU stored to IO_ADDR.
- io_strobe  out  1  one-cycle pulse, the cycle after the store to IO_ADDR.

Behaviour:
- Reset values:
  - state=IDLE, ptr=0, remaining=0, release counter=0.
  - cpu_reset=1, load_ready=0, load_done=0, io_out=0x00, io_strobe=0.
  - RAM contents are not cleared.
- States:
  - IDLE: cpu_reset=1, load_ready=0. load_start -> LOAD with ptr=0 and remaining=load_len (0 => 256).
  - LOAD: cpu_reset=1, load_ready=1. On each cycle with load_valid&&load_ready:
    - RAM[ptr]<=load_data, ptr<=ptr+1 (wraps mod 256), remaining--.
    - When the accepted byte is the last one -> RELEASE with counter=RELEASE_CYCLES.
    - load_start in LOAD is ignored.
  - RELEASE: cpu_reset=1, load_ready=0. Counter decrements each cycle; at 1 -> RUN. load_done pulses in the first RUN cycle.
  - RUN: cpu_reset=0. load_start -> LOAD (cpu_reset=1 from the next cycle) and the RAM is reloaded from address 0.
- Read path (combinational, zero latency):
  - memdata = RAM[adr] when state==RUN && memread, else 0x00.
  - The core latches memdata on the same edge it asserts memread.
- Write path:
  - In RUN with memwrite=1, RAM[adr]<=writedata at the clock edge.
  - If memread and memwrite are both high, memdata shows the pre-write contents during that cycle.
  - In any other state, memwrite is ignored.
- IO register: a RUN-state write with adr==IO_ADDR also sets io_out<=writedata and io_strobe=1 for exactly one cycle (registered). The RAM at IO_ADDR is written too.
- Write-port arbitration: only one source is ever active (loader in LOAD, CPU in RUN), so a mux selected by state suffices and there is no conflict.
- Back-pressure: load_valid gaps are allowed, and ptr/remaining hold during gaps. load_data is don't-care when load_valid=0.
- Reset mid-LOAD or mid-RUN:
  - Returns to IDLE and cpu_reset=1.
  - Partially loaded bytes remain in RAM.
  - io_out clears to 0x00.

Decomposition:
- Package mips_mem_pkg:
  - State enum {IDLE, LOAD, RELEASE, RUN}.
  - Default IO_ADDR constant.
  - RAM_DEPTH constant.
- Sub-module mem_array_256x8:
  - Single clocked write port (we, wa, wd).
  - One combinational read port (ra, rd).
  - No reset.
- Top level holds the FSM, pointer/counters, write mux, read gating and IO register.

Test Plan:
- Basic load and release:
  - Stimulus: reset, then load_start with load_len=4, then bytes 0x80,0x01,0x00,0x80 on consecutive cycles.
  - Response: RAM[0..3] hold those values; load_ready drops after the 4th byte; cpu_reset stays 1 for 2 more cycles, then 0; load_done pulses once.
- Back-pressure:
  - Stimulus: same 4-byte load with load_valid toggling 1,0,0,1,1,0,1.
  - Response: identical RAM contents; exactly 4 writes; RELEASE is entered only after the 4th accepted byte.
- CPU store, load and IO:
  - Stimulus: in RUN, memwrite adr=0x10 data=0x5A, then memread adr=0x10.
  - Response: memdata=0x5A in the read cycle.
  - Stimulus: memwrite adr=0xFF data=0x2C.
  - Response: io_out=0x2C with a one-cycle io_strobe; memdata=0x00 whenever memread=0.
- Simultaneous read/write and gating:
  - Stimulus: RAM[0x20]=0x11, then memread=memwrite=1 adr=0x20 data=0x22.
  - Response: memdata=0x11 that cycle; a following read returns 0x22.
  - Stimulus: memwrite during LOAD.
  - Response: no RAM change.
- Full-depth wrap:
  - Stimulus: load_len=0, 256 bytes with value equal to the index.
  - Response: RAM[i]=i for all i; ptr wraps to 0; RUN is entered after exactly 256 accepts.
- Reset and reload:
  - Stimulus: reset after 2 of 4 bytes.
  - Response: IDLE, cpu_reset=1, load_ready=0, RAM[0..1] retained.
  - Stimulus: load_start in RUN.
  - Response: cpu_reset rises the next cycle and loading restarts at address 0.
